uart_io_unit: RTL
=================

# uart_io_unit

Buffered UART I/O unit for the execute stage. It replaces the inline byte FIFOs and IN/OUT handling with a standalone block. It provides parametrised RX/TX FIFO depths, single-byte or multi-byte word transfers per request, a one-shot load-mode sync byte, and overflow reporting. It sits between the execute stage's IN/OUT instructions and the existing `uart_rx`/`uart_tx` modules, which it instantiates.

## Interface
Parameters:
- `CLK_PER_HALF_BIT`, 434: passed unchanged to `uart_rx`/`uart_tx`.
- `RX_LOG2`, 11: RX FIFO address width. Capacity is 2^RX_LOG2 − 1 bytes.
- `TX_LOG2`, 11: TX FIFO address width. Capacity is 2^TX_LOG2 − 1 bytes.
- `WORD_BYTES`, 4: bytes per word-mode transfer. Legal range 1..4.
- `SYNC_BYTE`, 8'hAA: byte sent once in load mode and detected on RX.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `rxd` in 1: serial input.
- `txd` out 1: serial output, driven by `uart_tx`.
- `mode` in 3: 1 = load, 2 = exec. Other values = idle.
- `req` in 1: single-cycle pulse that starts an IN or OUT.
- `req_out` in 1: 1 = OUT, 0 = IN. Sampled with `req`.
- `req_word` in 1: 1 = WORD_BYTES bytes, 0 = one byte. Sampled with `req`.
- `wdata` in 32: OUT data. Sampled with `req`.
- `rdata` out 32: IN result.
- `busy` out 1: combinational, `req | (state != IDLE)`.
- `done` out 1: one-cycle completion pulse.
- `sync_sent` out 1: sticky; load-mode sync byte has fully left `txd`.
- `sync_rx` out 1: one-cycle pulse when a received byte equals SYNC_BYTE, in any mode.
- `rx_overflow` out 1: sticky; an RX byte was dropped because the FIFO was full.
- `rx_level` out RX_LOG2: current RX FIFO occupancy.

## Operation
- **FIFOs.** Each FIFO is a circular buffer with top/bot pointers, distributed RAM, and the one-slot-empty rule.
  - Empty: top == bot.
  - Full: top + 1 == bot, with pointers wrapping modulo 2^LOG2.
- **RX push.** Push happens when `mode == 2` and `rx_ready`.
  - If the FIFO is full, the byte is dropped, `rx_overflow` is set, and the pointers are unchanged.
  - Push and pop in the same cycle are both performed.
- **TX drain.** In a cycle where `tx_start` is low, `~tx_busy`, and the FIFO is non-empty: load `odata` from `txbuffer[bot]`, advance bot, and pulse `tx_start` for one cycle. `tx_start` is never high on two consecutive cycles.
- **Sync.** While `mode == 1` and the sync byte has not yet been queued, and the TX FIFO is empty: push SYNC_BYTE and set the internal `sync_queued` flag.
  - `sync_sent` is set in the first cycle where `sync_queued`, the TX FIFO is empty, `~tx_start`, and `~tx_busy` all hold.
  - The sync byte is sent once per reset.
- **FSM states:**
  - IDLE → RD on `req & ~req_out`.
  - IDLE → WR on `req & req_out`.
  - At the `req` edge: latch `n = req_word ? WORD_BYTES : 1`, clear byte index `k`, latch `wdata` into `wbuf`, and clear `rbuf`.
  - RD: each cycle the RX FIFO is non-empty, pop into `rbuf[8k+7:8k]` and increment `k`. After the pop with k == n−1: copy `rbuf` (with the final byte merged) to `rdata` and go to IDLE.
  - WR: each cycle the TX FIFO is not full, push `wbuf[8k+7:8k]` and increment `k`. After the push with k == n−1: go to IDLE.
  - An OUT push has priority over a sync push in the same cycle. The sync push retries in a later cycle.
- **Byte order and width.** Little-endian: the first byte lands in `rdata[7:0]`. Unused upper bytes of `rdata` are zero.
- **`req` while not IDLE** is ignored. An IN in a mode other than 2 waits indefinitely.

## Timing
- **Reset values:**
  - `rdata` = 0, `done` = 0, `busy` = `req`, `sync_sent` = 0, `sync_rx` = 0, `rx_overflow` = 0, `rx_level` = 0.
  - `txd` = 1, `tx_start` = 0, FSM = IDLE.
  - Both FIFOs empty, `sync_queued` = 0.
- **Reset mid-transfer** aborts it. Partial `rbuf` contents and queued bytes are discarded, and no `done` pulse is produced.
- **`done`** is registered. It goes high in the cycle after the final byte's pop or push, which is the same cycle in which the state is IDLE and `busy` falls (absent a new `req`).
- **`rdata`** updates on the same edge that raises `done`, and holds until the next IN completes.
- **Minimum latency** from the `req` cycle c:
  - IN byte with the FIFO non-empty: pop at c+1, `done` at c+2.
  - WORD_BYTES = 4 word with no stalls: `done` at c+5.
- **RX availability.** A byte pushed at edge t is poppable in cycle t+1 at the earliest. An empty FIFO stalls RD without a timeout.
- **`sync_rx`** is high in the same cycle as the matching `rx_ready`.

## Test plan
- Reset, then idle with `mode = 0` → all outputs at reset values, `txd` = 1 throughout, and no `tx_start`.
- `mode = 1` for 20 bit-times → exactly one 0xAA frame on `txd`; `sync_sent` rises after its stop bit and stays high; no second frame.
- `mode = 2`, send bytes 0x11,0x22,0x33,0x44, then IN word (`req_word` = 1) → `rdata` = 0x44332211 with a one-cycle `done`; `rx_level` returns to 0. A following IN byte stalls with `busy` high until 0x55 arrives, then `rdata` = 0x00000055.
- OUT word `wdata` = 0xDEADBEEF, then OUT byte 0x7F → `txd` frames in order EF, BE, AD, DE, 7F, with exactly one `done` per request.
- `RX_LOG2 = 2`, `mode = 2`, send 4 bytes with no IN → first 3 bytes are kept and the 4th is dropped; `rx_overflow` = 1 and `rx_level` = 3. Subsequent INs return the first 3 bytes in order.
- Assert `rstn = 0` while an IN word has popped 2 of 4 bytes → no `done`, `rdata` = 0, FIFOs empty, state IDLE. A new IN then proceeds normally.

Source files
------------

// File: rtl/uart_io_unit.sv
// -----------------------------------------------------------------------------
// uart_io_unit
//   Buffered UART I/O for the execute stage. Bytes arriving on rxd are queued
//   in an RX FIFO while in exec mode; IN requests pop one byte or a little-endian
//   word from it. OUT requests push one byte or a word into a TX FIFO that is
//   drained into uart_tx. In load mode a single sync byte is sent once per reset.
//
// Ports
//   clk, rstn      clock, synchronous active-low reset
//   rxd / txd      serial input / output
//   mode           1 = load, 2 = exec, other = idle
//   req            one-cycle pulse starting an IN (req_out=0) or OUT (req_out=1)
//   req_word       1 = WORD_BYTES bytes, 0 = single byte (sampled with req)
//   wdata          OUT data (sampled with req)
//   rdata          IN result, little-endian, unused upper bytes zero
//   busy           req | (state != IDLE)
//   done           one-cycle completion pulse, cycle after the last byte moves
//   sync_sent      sticky, sync byte has fully left txd
//   sync_rx        pulse when a received byte equals SYNC_BYTE (any mode)
//   rx_overflow    sticky, an RX byte was dropped on a full FIFO
//   rx_level       RX FIFO occupancy
// -----------------------------------------------------------------------------
module uart_io_unit #(
    parameter int         CLK_PER_HALF_BIT = 434,
    parameter int         RX_LOG2          = 11,
    parameter int         TX_LOG2          = 11,
    parameter int         WORD_BYTES       = 4,   // legal range 1..4
    parameter logic [7:0] SYNC_BYTE        = 8'hAA
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               rxd,
    output logic               txd,
    input  logic [2:0]         mode,
    input  logic               req,
    input  logic               req_out,
    input  logic               req_word,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               busy,
    output logic               done,
    output logic               sync_sent,
    output logic               sync_rx,
    output logic               rx_overflow,
    output logic [RX_LOG2-1:0] rx_level
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_EXEC = 3'd2;
    localparam logic [1:0] WORD_LAST = 2'(WORD_BYTES - 1);

    // ---------------- serial front ends ----------------
    logic [7:0] rx_byte;
    logic       rx_ready;
    logic [7:0] odata;
    logic       tx_start;
    logic       tx_busy;

    uart_rx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_rx (
        .clk      (clk),
        .rstn     (rstn),
        .rxd      (rxd),
        .rdata    (rx_byte),
        .rx_ready (rx_ready)
    );

    uart_tx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_tx (
        .clk      (clk),
        .rstn     (rstn),
        .sdata    (odata),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .txd      (txd)
    );

    // ---------------- control signals ----------------
    state_t       state, state_next;
    logic [1:0]   k;          // byte index within the current transfer
    logic [1:0]   n_last;     // index of the final byte
    logic         last;
    logic [31:0]  wbuf;
    logic [31:0]  rbuf;
    logic [31:0]  rbuf_merged;
    logic         rx_pop;
    logic         wr_push;
    logic [7:0]   wr_byte;

    // ---------------- RX FIFO ----------------
    logic [7:0]         rx_mem [0:(1<<RX_LOG2)-1];
    logic [RX_LOG2-1:0] rx_top, rx_bot;
    logic               rx_empty, rx_full, rx_push;
    logic [7:0]         rx_head;

    assign rx_empty = (rx_top == rx_bot);
    assign rx_full  = (RX_LOG2'(rx_top + 1'b1) == rx_bot);
    assign rx_push  = (mode == MODE_EXEC) && rx_ready && !rx_full;
    assign rx_head  = rx_mem[rx_bot];
    assign rx_level = rx_top - rx_bot;
    assign sync_rx  = rx_ready && (rx_byte == SYNC_BYTE);

    // NOTE: FIFO storage has no reset; only the pointers define its contents,
    // which keeps it mappable to distributed RAM.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_top] <= rx_byte;
    end

    // NOTE: all state registers use non-blocking assignments so every block
    // sees the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_top      <= '0;
            rx_bot      <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (rx_push) rx_top <= rx_top + 1'b1;
            if (rx_pop)  rx_bot <= rx_bot + 1'b1;
            if ((mode == MODE_EXEC) && rx_ready && rx_full) rx_overflow <= 1'b1;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]         tx_mem [0:(1<<TX_LOG2)-1];
    logic [TX_LOG2-1:0] tx_top, tx_bot;
    logic               tx_empty, tx_full, tx_push, sync_push, drain;
    logic [7:0]         tx_push_byte;
    logic               sync_queued;

    assign tx_empty     = (tx_top == tx_bot);
    assign tx_full      = (TX_LOG2'(tx_top + 1'b1) == tx_bot);
    // An OUT push wins; the sync push simply retries on a later cycle.
    assign sync_push    = (mode == MODE_LOAD) && !sync_queued && tx_empty && !wr_push;
    assign tx_push      = wr_push || sync_push;
    assign tx_push_byte = wr_push ? wr_byte : SYNC_BYTE;
    // Gating on tx_start keeps it from ever being high two cycles in a row.
    assign drain        = !tx_start && !tx_busy && !tx_empty;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_top] <= tx_push_byte;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_top      <= '0;
            tx_bot      <= '0;
            tx_start    <= 1'b0;
            odata       <= 8'h00;
            sync_queued <= 1'b0;
            sync_sent   <= 1'b0;
        end else begin
            if (tx_push) tx_top <= tx_top + 1'b1;
            tx_start <= drain;
            if (drain) begin
                odata  <= tx_mem[tx_bot];
                tx_bot <= tx_bot + 1'b1;
            end
            if (sync_push) sync_queued <= 1'b1;
            if (sync_queued && tx_empty && !tx_start && !tx_busy) sync_sent <= 1'b1;
        end
    end

    // ---------------- request FSM ----------------
    assign busy    = req || (state != IDLE);
    assign last    = (k == n_last);
    assign wr_byte = wbuf[{k, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        rx_pop     = 1'b0;
        wr_push    = 1'b0;
        unique case (state)
            IDLE: if (req) state_next = req_out ? WR : RD;
            RD: if (!rx_empty) begin
                rx_pop = 1'b1;
                if (last) state_next = IDLE;
            end
            WR: if (!tx_full) begin
                wr_push = 1'b1;
                if (last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // rbuf with the byte being popped this cycle already in place.
    always_comb begin
        rbuf_merged = rbuf;
        rbuf_merged[{k, 3'b000} +: 8] = rx_head;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            k      <= 2'd0;
            n_last <= 2'd0;
            wbuf   <= '0;
            rbuf   <= '0;
            rdata  <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: if (req) begin
                    n_last <= req_word ? WORD_LAST : 2'd0;
                    k      <= 2'd0;
                    wbuf   <= wdata;
                    rbuf   <= '0;
                end
                RD: if (rx_pop) begin
                    rbuf <= rbuf_merged;
                    k    <= k + 2'd1;
                    if (last) begin
                        rdata <= rbuf_merged;
                        done  <= 1'b1;
                    end
                end
                WR: if (wr_push) begin
                    k <= k + 2'd1;
                    if (last) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// -----------------------------------------------------------------------------
// uart_tx
//   8N1 transmitter. A tx_start pulse while idle loads sdata; tx_busy stays
//   high until the end of the stop bit. txd idles high.
// Ports: clk, rstn, sdata, tx_start in; tx_busy, txd out.
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLK_PER_HALF_BIT = 434
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] sdata,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       txd
);
    localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
    localparam int CW       = $clog2(BIT_CLKS);

    logic [CW-1:0] cnt;
    logic [3:0]    bits_left;
    logic [9:0]    shreg;   // {stop, data, start}; shifts in ones so it idles high

    assign txd = shreg[0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt       <= '0;
            bits_left <= 4'd0;
            shreg     <= '1;
            tx_busy   <= 1'b0;
        end else if (!tx_busy) begin
            if (tx_start) begin
                shreg     <= {1'b1, sdata, 1'b0};
                bits_left <= 4'd10;
                cnt       <= '0;
                tx_busy   <= 1'b1;
            end
        end else if (cnt == CW'(BIT_CLKS - 1)) begin
            cnt       <= '0;
            shreg     <= {1'b1, shreg[9:1]};
            bits_left <= bits_left - 4'd1;
            if (bits_left == 4'd1) tx_busy <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// -----------------------------------------------------------------------------
// uart_rx
//   8N1 receiver. Synchronises rxd, samples each bit at its centre and pulses
//   rx_ready for one cycle with rdata valid when a frame with a good stop bit
//   completes.
// Ports: clk, rstn, rxd in; rdata, rx_ready out.
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_PER_HALF_BIT = 434
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic [7:0] rdata,
    output logic       rx_ready
);
    localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
    localparam int CW       = $clog2(BIT_CLKS);

    logic          rx_meta, rx_sync;
    logic          active;
    logic [3:0]    idx;     // 0 = start, 1..8 = data, 9 = stop
    logic [CW-1:0] cnt;
    logic [7:0]    shreg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            active   <= 1'b0;
            idx      <= 4'd0;
            cnt      <= '0;
            shreg    <= 8'h00;
            rdata    <= 8'h00;
            rx_ready <= 1'b0;
        end else begin
            rx_meta  <= rxd;
            rx_sync  <= rx_meta;
            rx_ready <= 1'b0;
            if (!active) begin
                if (!rx_sync) begin
                    active <= 1'b1;
                    idx    <= 4'd0;
                    cnt    <= CW'(CLK_PER_HALF_BIT - 1);
                end
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                cnt <= CW'(BIT_CLKS - 1);
                idx <= idx + 4'd1;
                if (idx == 4'd0) begin
                    if (rx_sync) active <= 1'b0;   // start bit was a glitch
                end else if (idx == 4'd9) begin
                    active <= 1'b0;
                    if (rx_sync) begin
                        rdata    <= shreg;
                        rx_ready <= 1'b1;
                    end
                end else begin
                    shreg <= {rx_sync, shreg[7:1]};
                end
            end
        end
    end
endmodule
